wb_flash_rd: RTL and testbench

WB_FLASH_RD -- requirements
Module: wb_flash_rd

---
 rtl/wb_flash_rd_if.sv | 16 +
 rtl/wb_flash_rd.sv | 83 ++++++++
 tb/tb_wb_flash_rd.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/wb_flash_rd_if.sv
// Wishbone classic slave bus bundle for the flash read bridge.
interface wb_flash_rd_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;

  modport master (output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
                  input  wb_dat_o, wb_ack_o);
  modport slave  (input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
                  output wb_dat_o, wb_ack_o);
endinterface

// File: rtl/wb_flash_rd.sv
// Read-only Wishbone bridge to an 8-bit parallel flash: four byte reads per word,
// each byte address held WAIT_CYCLES clocks, packed big-endian.
module wb_flash_rd #(
  parameter int WAIT_CYCLES = 4,
  parameter int FLASH_AW    = 22
) (
  input  logic                clk,
  input  logic                rst,
  wb_flash_rd_if.slave        wb,
  output logic [FLASH_AW-1:0] flash_adr_o,
  input  logic [7:0]          flash_dat_i,
  output logic                flash_ce_o,
  output logic                flash_oe_o,
  output logic                flash_we_o,
  output logic                flash_rst_o
);
  typedef enum logic [1:0] {IDLE, READ, ACK} state_t;

  localparam logic [3:0] WLAST = 4'(WAIT_CYCLES - 1);

  state_t                state, state_nxt;
  logic [3:0]            wcnt;
  logic [1:0]            idx;
  logic [FLASH_AW-3:0]   base_w;
  logic [3:0][7:0]       buf_q;
  logic [31:0]           dat_q;
  logic                  req, strobe;

  assign req    = wb.wb_cyc_i & wb.wb_stb_i;
  assign strobe = (state == READ) && (wcnt == WLAST);

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req) state_nxt = wb.wb_we_i ? ACK : READ;
      READ: if (!req)                     state_nxt = IDLE;
            else if (strobe && idx == 2'd3) state_nxt = ACK;
      ACK:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bytes collect in buf_q; dat_q only updates on a full word so aborts leave it intact.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wcnt   <= '0;
      idx    <= '0;
      base_w <= '0;
      buf_q  <= '0;
      dat_q  <= '0;
    end else begin
      if (state == IDLE && req && !wb.wb_we_i) begin
        wcnt   <= '0;
        idx    <= '0;
        base_w <= wb.wb_adr_i[FLASH_AW-1:2];
      end else if (state == READ && req) begin
        if (strobe) begin
          wcnt       <= '0;
          idx        <= idx + 2'd1;
          buf_q[~idx] <= flash_dat_i;
          if (idx == 2'd3) dat_q <= {buf_q[3], buf_q[2], buf_q[1], flash_dat_i};
        end else begin
          wcnt <= wcnt + 4'd1;
        end
      end
    end

  // Low base bits are zero, so base+idx is a concatenation and never carries.
  assign flash_adr_o = (state == READ) ? {base_w, idx} : '0;
  assign flash_ce_o  = (state != READ);
  assign flash_oe_o  = (state != READ);
  assign flash_we_o  = 1'b1;
  assign flash_rst_o = rst;
  assign wb.wb_ack_o = (state == ACK);
  assign wb.wb_dat_o = dat_q;

  logic unused_bits;
  assign unused_bits = ^{wb.wb_dat_i, wb.wb_sel_i, wb.wb_adr_i[31:FLASH_AW], wb.wb_adr_i[1:0]};
endmodule

// File: tb/tb_wb_flash_rd.sv
// Scoreboard bench for wb_flash_rd: default-wait instance plus a WAIT_CYCLES=1 instance.
module tb_wb_flash_rd;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];

  wb_flash_rd_if wba();
  wb_flash_rd_if wbb();

  logic [21:0] adr_a, adr_b;
  logic [7:0]  fd_a, fd_b;
  logic ce_a, oe_a, we_a, fr_a, ce_b, oe_b, we_b, fr_b;

  assign fd_a = adr_a[7:0];
  assign fd_b = adr_b[7:0];

  wb_flash_rd #(.WAIT_CYCLES(4), .FLASH_AW(22)) dut_a (
    .clk(clk), .rst(rst), .wb(wba.slave), .flash_adr_o(adr_a), .flash_dat_i(fd_a),
    .flash_ce_o(ce_a), .flash_oe_o(oe_a), .flash_we_o(we_a), .flash_rst_o(fr_a));

  wb_flash_rd #(.WAIT_CYCLES(1), .FLASH_AW(22)) dut_b (
    .clk(clk), .rst(rst), .wb(wbb.slave), .flash_adr_o(adr_b), .flash_dat_i(fd_b),
    .flash_ce_o(ce_b), .flash_oe_o(oe_b), .flash_we_o(we_b), .flash_rst_o(fr_b));

  task automatic idle_bus();
    wba.wb_cyc_i = 0; wba.wb_stb_i = 0; wba.wb_we_i = 0;
    wba.wb_adr_i = '0; wba.wb_dat_i = '0; wba.wb_sel_i = 4'hF;
    wbb.wb_cyc_i = 0; wbb.wb_stb_i = 0; wbb.wb_we_i = 0;
    wbb.wb_adr_i = '0; wbb.wb_dat_i = '0; wbb.wb_sel_i = 4'hF;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({wba.wb_ack_o, wba.wb_dat_o, adr_a, ce_a, oe_a, we_a, fr_a} !==
        {1'b0, 32'h0, 22'h0, 1'b1, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_a: ack=%b dat=%h adr=%h ce=%b oe=%b we=%b rst_o=%b",
        wba.wb_ack_o, wba.wb_dat_o, adr_a, ce_a, oe_a, we_a, fr_a);
    end
    checks++;
    if ({wbb.wb_ack_o, wbb.wb_dat_o, ce_b, fr_b} !== {1'b0, 32'h0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_b: ack=%b dat=%h ce=%b rst_o=%b",
        wbb.wb_ack_o, wbb.wb_dat_o, ce_b, fr_b);
    end
    @(negedge clk); rst = 1;
    @(negedge clk);
    checks++;
    if (fr_a !== 1'b1 || we_a !== 1'b1) begin
      errors++; $display("FAIL rst_release: flash_rst_o=%b flash_we_o=%b want 1 1", fr_a, we_a);
    end
  endtask

  task automatic test_read(input logic [31:0] adr, input logic [31:0] exp, input string nm);
    int cnt = 0;
    logic [21:0] base = {adr[21:2], 2'b00};
    logic [21:0] ea;
    logic [31:0] got;
    sb_q.push_back(exp);
    wba.wb_adr_i = adr; wba.wb_we_i = 0; wba.wb_cyc_i = 1; wba.wb_stb_i = 1;
    while (cnt < 60) begin
      @(negedge clk); cnt++;
      if (wba.wb_ack_o) break;
      ea = base + 22'((cnt - 1) / 4);
      if (adr_a !== ea || ce_a !== 1'b0 || oe_a !== 1'b0) begin
        checks++; errors++;
        $display("FAIL %s_addr cyc %0d: adr=%h ce=%b oe=%b want %h 0 0", nm, cnt, adr_a, ce_a, oe_a, ea);
      end
    end
    checks++;
    if (cnt !== 17) begin
      errors++; $display("FAIL %s_latency: got %0d cycles want 17", nm, cnt);
    end
    got = sb_q.pop_front();
    checks++;
    if (wba.wb_dat_o !== got) begin
      errors++; $display("FAIL %s_data: got %h want %h", nm, wba.wb_dat_o, got);
    end
    wba.wb_cyc_i = 0; wba.wb_stb_i = 0;
    @(negedge clk);
    checks++;
    if (wba.wb_ack_o !== 1'b0 || wba.wb_dat_o !== got || ce_a !== 1'b1) begin
      errors++; $display("FAIL %s_after: ack=%b dat=%h ce=%b want 0 %h 1", nm, wba.wb_ack_o, wba.wb_dat_o, ce_a, got);
    end
  endtask

  task automatic test_write(input logic [31:0] held);
    wba.wb_adr_i = 32'h20; wba.wb_dat_i = 32'hDEADBEEF; wba.wb_we_i = 1;
    wba.wb_cyc_i = 1; wba.wb_stb_i = 1;
    @(negedge clk);
    checks++;
    if (wba.wb_ack_o !== 1'b1 || ce_a !== 1'b1 || oe_a !== 1'b1 || wba.wb_dat_o !== held) begin
      errors++; $display("FAIL write_ack: ack=%b ce=%b oe=%b dat=%h want 1 1 1 %h",
        wba.wb_ack_o, ce_a, oe_a, wba.wb_dat_o, held);
    end
    wba.wb_cyc_i = 0; wba.wb_stb_i = 0; wba.wb_we_i = 0;
    @(negedge clk);
    checks++;
    if (wba.wb_ack_o !== 1'b0 || ce_a !== 1'b1 || wba.wb_dat_o !== held) begin
      errors++; $display("FAIL write_after: ack=%b ce=%b dat=%h want 0 1 %h", wba.wb_ack_o, ce_a, wba.wb_dat_o, held);
    end
  endtask

  task automatic test_abort(input logic [31:0] held);
    int acks = 0;
    wba.wb_adr_i = 32'h80; wba.wb_we_i = 0; wba.wb_cyc_i = 1; wba.wb_stb_i = 1;
    repeat (6) @(negedge clk);
    checks++;
    if (ce_a !== 1'b0 || adr_a !== 22'h81) begin
      errors++; $display("FAIL abort_mid: ce=%b adr=%h want 0 81", ce_a, adr_a);
    end
    wba.wb_cyc_i = 0;
    @(negedge clk);
    checks++;
    if (ce_a !== 1'b1 || oe_a !== 1'b1 || wba.wb_ack_o !== 1'b0 || wba.wb_dat_o !== held) begin
      errors++; $display("FAIL abort_idle: ce=%b oe=%b ack=%b dat=%h want 1 1 0 %h",
        ce_a, oe_a, wba.wb_ack_o, wba.wb_dat_o, held);
    end
    wba.wb_stb_i = 0;
    repeat (20) begin @(negedge clk); if (wba.wb_ack_o) acks++; end
    checks++;
    if (acks !== 0) begin
      errors++; $display("FAIL abort_noack: got %0d acks want 0", acks);
    end
  endtask

  task automatic test_async_reset();
    wba.wb_adr_i = 32'h10; wba.wb_we_i = 0; wba.wb_cyc_i = 1; wba.wb_stb_i = 1;
    repeat (5) @(negedge clk);
    #2 rst = 0;
    #1;
    checks++;
    if ({wba.wb_ack_o, wba.wb_dat_o, adr_a, ce_a, oe_a, we_a, fr_a} !==
        {1'b0, 32'h0, 22'h0, 1'b1, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL async_reset: ack=%b dat=%h adr=%h ce=%b oe=%b we=%b rst_o=%b",
        wba.wb_ack_o, wba.wb_dat_o, adr_a, ce_a, oe_a, we_a, fr_a);
    end
    wba.wb_cyc_i = 0; wba.wb_stb_i = 0;
    @(negedge clk); rst = 1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cnt;
    logic [31:0] got;
    logic [31:0] adrs [2] = '{32'h40, 32'h105};
    logic [31:0] exps [2] = '{32'h40414243, 32'h04050607};
    wbb.wb_we_i = 0; wbb.wb_cyc_i = 1; wbb.wb_stb_i = 1;
    for (int t = 0; t < 2; t++) begin
      wbb.wb_adr_i = adrs[t];
      sb_q.push_back(exps[t]);
      if (t > 0) begin
        @(negedge clk);
        checks++;
        if (wbb.wb_ack_o !== 1'b0 || ce_b !== 1'b1) begin
          errors++; $display("FAIL b2b_gap: ack=%b ce=%b want 0 1", wbb.wb_ack_o, ce_b);
        end
      end
      cnt = 0;
      while (cnt < 30) begin
        @(negedge clk); cnt++;
        if (wbb.wb_ack_o) break;
      end
      checks++;
      if (cnt !== 5) begin
        errors++; $display("FAIL b2b_latency%0d: got %0d cycles want 5", t, cnt);
      end
      got = sb_q.pop_front();
      checks++;
      if (wbb.wb_dat_o !== got) begin
        errors++; $display("FAIL b2b_data%0d: got %h want %h", t, wbb.wb_dat_o, got);
      end
    end
    wbb.wb_cyc_i = 0; wbb.wb_stb_i = 0;
    @(negedge clk);
  endtask

  initial begin
    idle_bus();
    test_reset();
    test_read(32'h0000_0010, 32'h10111213, "read");
    test_write(32'h10111213);
    test_read(32'h003F_FFFE, 32'hFCFDFEFF, "unaligned");
    test_abort(32'hFCFDFEFF);
    test_async_reset();
    test_read(32'h0000_0010, 32'h10111213, "post_reset");
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
